// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem requests,
// buffers one response for decode, and discards responses made stale by a redirect.
module fetch_ctrl #(
   parameter int                  ARCH_LEN  = 32,
   parameter int                  INST_LEN  = 32,
   parameter logic [ARCH_LEN-1:0] BOOT_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   output logic [ARCH_LEN-1:0] imem_req_addr,
   input  logic                imem_req_ready,
   input  logic                imem_rsp_valid,
   input  logic [INST_LEN-1:0] imem_rsp_data,
   input  logic                redirect_valid,
   input  logic [ARCH_LEN-1:0] redirect_pc,
   input  logic                stall_in,
   output logic                inst_valid_out,
   output logic [INST_LEN-1:0] inst_out,
   output logic [ARCH_LEN-1:0] inst_pc_out
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ARCH_LEN-1:0] r_pc;
   logic [ARCH_LEN-1:0] w_pc_nxt;
   logic                r_inst_valid;
   logic                w_inst_valid_nxt;
   logic [INST_LEN-1:0] r_inst;
   logic [ARCH_LEN-1:0] r_inst_pc;
   logic                w_buf_wr;
   logic                w_buffer_free;
   logic                w_accept;
   logic                w_consume;
   logic [ARCH_LEN-1:0] w_redirect_aligned;

   assign w_buffer_free      = !r_inst_valid || !stall_in;
   assign imem_req_valid     = (r_state == S_REQ) && w_buffer_free;
   assign imem_req_addr      = r_pc;
   assign w_accept           = imem_req_valid && imem_req_ready;
   assign w_consume          = r_inst_valid && !stall_in;
   assign w_redirect_aligned = {redirect_pc[ARCH_LEN-1:2], 2'b00};

   assign inst_valid_out = r_inst_valid;
   assign inst_out       = r_inst;
   assign inst_pc_out    = r_inst_pc;

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_buf_wr         = 1'b0;
      w_inst_valid_nxt = r_inst_valid && !w_consume;

      case (r_state)
         S_BOOT: begin
            // Responses arriving here belong to a request issued before reset.
            w_state_nxt      = S_REQ;
            w_inst_valid_nxt = r_inst_valid;
         end
         S_REQ: begin
            if (w_accept) begin
               w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_state_nxt = S_REQ;
               if (!redirect_valid) begin
                  w_buf_wr         = 1'b1;
                  w_inst_valid_nxt = 1'b1;
                  w_pc_nxt         = r_pc + ARCH_LEN'(4);
               end
            end else if (redirect_valid) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem_rsp_valid) begin
               w_state_nxt = S_REQ;
            end
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase

      // Redirect outranks everything except the boot cycle.
      if (redirect_valid && (r_state != S_BOOT)) begin
         w_pc_nxt         = w_redirect_aligned;
         w_inst_valid_nxt = 1'b0;
         w_buf_wr         = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_BOOT;
         r_pc         <= BOOT_ADDR;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_inst_pc    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         if (w_buf_wr) begin
            r_inst    <= imem_rsp_data;
            r_inst_pc <= r_pc;
         end
      end
   end

endmodule
